// File: rtl/demux_stream_buf.sv
// demux_stream_buf: registered 1:2 stream demux, each channel has a 2-entry FIFO and an accept counter
module demux_stream_buf #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] I,
    input  logic             S,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Y0,
    output logic             y0_valid,
    input  logic             y0_ready,
    output logic [WIDTH-1:0] Y1,
    output logic             y1_valid,
    input  logic             y1_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    logic [WIDTH-1:0] head_q [2];
    logic [WIDTH-1:0] head_d [2];
    logic [WIDTH-1:0] tail_q [2];
    logic [WIDTH-1:0] tail_d [2];
    logic [1:0]       occ_q  [2];
    logic [1:0]       occ_d  [2];
    logic [CNT_W-1:0] cnt_q  [2];
    logic [CNT_W-1:0] cnt_d  [2];
    logic [1:0]       vld;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_rdy;

    assign vld      = {occ_q[1] != 2'd0, occ_q[0] != 2'd0};
    assign full     = {occ_q[1] == 2'd2, occ_q[0] == 2'd2};
    assign out_rdy  = {y1_ready, y0_ready};
    // in_ready ignores same-cycle pops so yk_ready never reaches it combinationally
    assign in_ready = rst_n & ~full[S];
    assign push     = {in_valid & in_ready & S, in_valid & in_ready & ~S};
    assign pop      = vld & out_rdy;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            head_d[k] = head_q[k];
            tail_d[k] = tail_q[k];
            occ_d[k]  = occ_q[k];
            cnt_d[k]  = cnt_q[k] + CNT_W'(push[k]);
            if (occ_q[k] == 2'd0) begin
                if (push[k]) begin
                    head_d[k] = I;
                    occ_d[k]  = 2'd1;
                end
            end else if (occ_q[k] == 2'd1) begin
                if (push[k] && pop[k]) begin
                    head_d[k] = I;
                end else if (push[k]) begin
                    tail_d[k] = I;
                    occ_d[k]  = 2'd2;
                end else if (pop[k]) begin
                    occ_d[k]  = 2'd0;
                end
            end else if (pop[k]) begin
                head_d[k] = tail_q[k];
                occ_d[k]  = 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                head_q[k] <= '0;
                tail_q[k] <= '0;
                occ_q[k]  <= 2'd0;
                cnt_q[k]  <= '0;
            end else begin
                head_q[k] <= head_d[k];
                tail_q[k] <= tail_d[k];
                occ_q[k]  <= occ_d[k];
                cnt_q[k]  <= cnt_d[k];
            end
        end
    end

    assign y0_valid = vld[0];
    assign y1_valid = vld[1];
    assign Y0       = vld[0] ? head_q[0] : '0;
    assign Y1       = vld[1] ? head_q[1] : '0;
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];
endmodule

// File: tb/tb_demux_stream_buf.sv
// tb_demux_stream_buf: directed and random stimulus against a queue-based channel model
module tb_demux_stream_buf;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_d = '0;
    logic       s = 1'b0;
    logic       in_valid = 1'b0;
    logic       y0_ready = 1'b0;
    logic       y1_ready = 1'b0;
    logic       in_ready, y0_valid, y1_valid;
    logic [7:0] y0, y1, cnt0, cnt1;
    logic       in_ready_w, y0_valid_w, y1_valid_w;
    logic [7:0] y0_w, y1_w;
    logic [1:0] cnt0_w, cnt1_w;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         c0 = 0;
    int         c1 = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    demux_stream_buf dut (
        .clk(clk), .rst_n(rst_n), .I(i_d), .S(s), .in_valid(in_valid), .in_ready(in_ready),
        .Y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
        .Y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready), .cnt0(cnt0), .cnt1(cnt1)
    );

    demux_stream_buf #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .I(i_d), .S(s), .in_valid(in_valid), .in_ready(in_ready_w),
        .Y0(y0_w), .y0_valid(y0_valid_w), .y0_ready(y0_ready),
        .Y1(y1_w), .y1_valid(y1_valid_w), .y1_ready(y1_ready), .cnt0(cnt0_w), .cnt1(cnt1_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc(input logic rn, input logic iv, input logic sel, input logic [7:0] d,
                       input logic r0, input logic r1);
        logic exp_rdy, p0, p1;
        @(negedge clk);
        rst_n = rn; in_valid = iv; s = sel; i_d = d; y0_ready = r0; y1_ready = r1;
        #1;
        exp_rdy = rn && ((sel ? q1.size() : q0.size()) < 2);
        check("in_ready", in_ready, exp_rdy);
        check("y0_valid", y0_valid, q0.size() > 0);
        check("Y0", y0, q0.size() > 0 ? q0[0] : 8'h00);
        check("y1_valid", y1_valid, q1.size() > 0);
        check("Y1", y1, q1.size() > 0 ? q1[0] : 8'h00);
        check("cnt0", cnt0, c0 % 256);
        check("cnt1", cnt1, c1 % 256);
        check("cnt0_w", cnt0_w, c0 % 4);
        check("cnt1_w", cnt1_w, c1 % 4);
        p0 = q0.size() > 0 && r0;
        p1 = q1.size() > 0 && r1;
        @(posedge clk);
        if (!rn) begin
            q0.delete(); q1.delete(); c0 = 0; c1 = 0;
        end else begin
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (iv && exp_rdy) begin
                if (sel) begin q1.push_back(d); c1++; end
                else begin q0.push_back(d); c0++; end
            end
        end
    endtask

    initial begin
        in_valid = 1'b1;
        @(posedge clk);
        cyc(0, 1, 0, 8'hFF, 1, 1);
        cyc(0, 1, 1, 8'hEE, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        // routing
        cyc(1, 1, 0, 8'hA5, 1, 1);
        cyc(1, 1, 1, 8'h3C, 1, 1);
        #1;
        check("t2_y1", y1, 8'h3C);
        check("t2_cnt0", cnt0, 1);
        check("t2_cnt1", cnt1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        // backpressure: third push refused, then drain in order
        cyc(1, 1, 0, 8'h01, 0, 1);
        cyc(1, 1, 0, 8'h02, 0, 1);
        cyc(1, 1, 0, 8'h03, 0, 1);
        cyc(1, 1, 0, 8'h04, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        // independence: ch0 full, ch1 still accepts
        cyc(1, 1, 0, 8'h11, 0, 1);
        cyc(1, 1, 0, 8'h12, 0, 1);
        cyc(1, 1, 1, 8'h77, 0, 1);
        #1;
        check("t4_y1", y1, 8'h77);
        check("t4_y0", y0, 8'h11);
        cyc(1, 0, 0, 8'h00, 1, 1);
        cyc(1, 0, 0, 8'h00, 1, 1);
        // simultaneous push+pop at occupancy 1
        cyc(1, 1, 1, 8'h10, 1, 0);
        cyc(1, 1, 1, 8'h20, 1, 1);
        #1;
        check("t5_y1", y1, 8'h20);
        check("t5_v1", y1_valid, 1);
        cyc(1, 0, 0, 8'h00, 1, 0);
        cyc(1, 0, 0, 8'h00, 1, 1);
        // counter wrap and reset discarding buffered words
        cyc(0, 0, 0, 8'h00, 1, 1);
        for (int k = 0; k < 5; k++) cyc(1, 1, 0, 8'h40 + 8'(k), 1, 1);
        #1;
        check("t6_cnt0_w", cnt0_w, 1);
        check("t6_cnt0", cnt0, 5);
        cyc(1, 0, 0, 8'h00, 1, 1);
        cyc(1, 1, 0, 8'h51, 0, 0);
        cyc(1, 1, 0, 8'h52, 0, 0);
        cyc(0, 0, 0, 8'h00, 1, 1);
        #1;
        check("t6_v0", y0_valid, 0);
        for (int k = 0; k < 3; k++) cyc(1, 0, 0, 8'h00, 1, 1);
        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(63) != 0, 1'($urandom), 1'($urandom), 8'($urandom),
                $urandom_range(3) != 0, $urandom_range(3) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
